// File: rtl/player_anim_ctrl.sv
// Per-player sprite sequencer: movement/hit/respawn events -> frame index, facing, visibility.
// Latency: outputs are registered; an input acted on at a tick shows the cycle after that tick.
// Backpressure: none; enable_i=0 freezes all state and counters, event pulses stay latched.
//
// Ports:
//   clk, resetN          pixel clock, asynchronous active-low reset
//   startOfFrame_i       one-cycle pulse per VGA frame (tick = startOfFrame_i & enable_i)
//   enable_i             0 = pause
//   moveReq_i[3:0]       {up,down,left,right} held requests
//   hitByBlast_i         one-cycle hit pulse (latched until the next tick)
//   respawn_i            one-cycle respawn pulse (latched until the next tick)
//   frameSel_o[3:0]      0 idle, 1..WALK_FRAMES walk, 8.. death
//   dirCode_o[1:0]       0 down, 1 up, 2 side
//   mirrorX_o            1 = facing left
//   visible_o            rectangle gate, blinks while invulnerable
//   isDead_o             high while dying or dead
//   invulnerable_o       high while the post-respawn counter is running
//   deathDone_o          one-cycle pulse when the dead hold has elapsed
module player_anim_ctrl #(
  parameter int FRAMES_PER_STEP = 6,
  parameter int WALK_FRAMES     = 4,
  parameter int DEATH_FRAMES    = 4,
  parameter int DEATH_HOLD      = 60,
  parameter int INVULN_FRAMES   = 120,
  parameter int BLINK_PERIOD    = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame_i,
  input  logic       enable_i,
  input  logic [3:0] moveReq_i,
  input  logic       hitByBlast_i,
  input  logic       respawn_i,
  output logic [3:0] frameSel_o,
  output logic [1:0] dirCode_o,
  output logic       mirrorX_o,
  output logic       visible_o,
  output logic       isDead_o,
  output logic       invulnerable_o,
  output logic       deathDone_o
);

  localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HOLD_W = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
  // +1 so the counter can hold the full load value itself
  localparam int INV_W  = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam int BLNK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(FRAMES_PER_STEP - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(DEATH_HOLD - 1);
  localparam logic [INV_W-1:0]  INV_INIT    = INV_W'(INVULN_FRAMES);
  localparam logic [INV_W-1:0]  INV_ONE     = INV_W'(1);
  localparam logic [BLNK_W-1:0] BLINK_LAST  = BLNK_W'(BLINK_PERIOD - 1);
  localparam logic [3:0]        WALK_LAST   = 4'(WALK_FRAMES);
  localparam logic [3:0]        DEATH_FIRST = 4'd8;
  localparam logic [3:0]        DEATH_LAST  = 4'(8 + DEATH_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DYING, S_DEAD} state_t;

  state_t              state_q, state_d;
  logic [3:0]          frame_q, frame_d;
  logic [1:0]          dir_q, dir_d;
  logic                mirror_q, mirror_d;
  logic                vis_q, vis_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [INV_W-1:0]    invuln_q, invuln_d;
  logic [BLNK_W-1:0]   blink_q, blink_d;
  logic                done_seen_q, done_seen_d;  // deathDone already fired for this death
  logic                hit_pend_q, hit_pend_d;
  logic                resp_pend_q, resp_pend_d;
  logic                done_q, done_d;

  logic tick;
  logic hit_evt;
  logic resp_evt;

  assign tick     = startOfFrame_i & enable_i;
  // a pulse landing on the tick cycle itself is seen at that tick
  assign hit_evt  = hit_pend_q | hitByBlast_i;
  assign resp_evt = resp_pend_q | respawn_i;

  // state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      frame_q     <= 4'd0;
      dir_q       <= 2'd0;
      mirror_q    <= 1'b0;
      vis_q       <= 1'b1;
      step_q      <= '0;
      hold_q      <= '0;
      invuln_q    <= '0;
      blink_q     <= '0;
      done_seen_q <= 1'b0;
      hit_pend_q  <= 1'b0;
      resp_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      dir_q       <= dir_d;
      mirror_q    <= mirror_d;
      vis_q       <= vis_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      invuln_q    <= invuln_d;
      blink_q     <= blink_d;
      done_seen_q <= done_seen_d;
      hit_pend_q  <= hit_pend_d;
      resp_pend_q <= resp_pend_d;
      done_q      <= done_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    dir_d       = dir_q;
    mirror_d    = mirror_q;
    vis_d       = vis_q;
    step_d      = step_q;
    hold_d      = hold_q;
    invuln_d    = invuln_q;
    blink_d     = blink_q;
    done_seen_d = done_seen_q;
    done_d      = 1'b0;
    hit_pend_d  = hit_evt;
    resp_pend_d = resp_evt;

    if (tick) begin
      // pending events are consumed (or discarded) at every tick
      hit_pend_d  = 1'b0;
      resp_pend_d = 1'b0;

      if (invuln_q != '0) begin
        invuln_d = invuln_q - 1'b1;
        if (invuln_q == INV_ONE) begin
          vis_d   = 1'b1;
          blink_d = '0;
        end else if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          vis_d   = ~vis_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end

      // facing: up > down > left > right, held when no request
      if ((state_q == S_IDLE || state_q == S_WALK) && moveReq_i != 4'b0000) begin
        if (moveReq_i[3]) begin
          dir_d = 2'd1; mirror_d = 1'b0;
        end else if (moveReq_i[2]) begin
          dir_d = 2'd0; mirror_d = 1'b0;
        end else if (moveReq_i[1]) begin
          dir_d = 2'd2; mirror_d = 1'b1;
        end else begin
          dir_d = 2'd2; mirror_d = 1'b0;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (hit_evt && invuln_q == '0) begin
            state_d = S_DYING; frame_d = DEATH_FIRST; step_d = '0;
          end else if (moveReq_i != 4'b0000) begin
            state_d = S_WALK; frame_d = 4'd1; step_d = '0;
          end
        end
        S_WALK: begin
          if (hit_evt && invuln_q == '0) begin
            state_d = S_DYING; frame_d = DEATH_FIRST; step_d = '0;
          end else if (moveReq_i == 4'b0000) begin
            state_d = S_IDLE; frame_d = 4'd0; step_d = '0;
          end else if (step_q == STEP_LAST) begin
            step_d  = '0;
            frame_d = (frame_q == WALK_LAST) ? 4'd1 : frame_q + 4'd1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        S_DYING: begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            if (frame_q == DEATH_LAST) begin
              state_d     = S_DEAD;
              hold_d      = '0;
              done_seen_d = 1'b0;
            end else begin
              frame_d = frame_q + 4'd1;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        S_DEAD: begin
          if (resp_evt && done_seen_q) begin
            state_d     = S_IDLE;
            frame_d     = 4'd0;
            dir_d       = 2'd0;
            mirror_d    = 1'b0;
            step_d      = '0;
            hold_d      = '0;
            done_seen_d = 1'b0;
            invuln_d    = INV_INIT;
            blink_d     = '0;
            // first blink half-period is the hidden one
            vis_d       = (INVULN_FRAMES == 0);
          end else if (!done_seen_q) begin
            if (hold_q == HOLD_LAST) begin
              done_d      = 1'b1;
              done_seen_d = 1'b1;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    frameSel_o     = frame_q;
    dirCode_o      = dir_q;
    mirrorX_o      = mirror_q;
    visible_o      = vis_q;
    isDead_o       = (state_q == S_DYING) || (state_q == S_DEAD);
    invulnerable_o = (invuln_q != '0);
    deathDone_o    = done_q;
  end

endmodule

// File: tb/tb_player_anim_ctrl.sv
module tb_player_anim_ctrl;

  localparam int FPS = 6;
  localparam int WF  = 4;
  localparam int DF  = 4;
  localparam int DH  = 60;
  localparam int INV = 120;
  localparam int BP  = 8;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof, en, hit, resp;
  logic [3:0] mv;
  logic [3:0] frameSel;
  logic [1:0] dirCode;
  logic       mirrorX, visible, isDead, invulnerable, deathDone;

  int total = 0;
  int bad   = 0;

  player_anim_ctrl #(
    .FRAMES_PER_STEP(FPS), .WALK_FRAMES(WF), .DEATH_FRAMES(DF),
    .DEATH_HOLD(DH), .INVULN_FRAMES(INV), .BLINK_PERIOD(BP)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame_i(sof), .enable_i(en),
    .moveReq_i(mv), .hitByBlast_i(hit), .respawn_i(resp),
    .frameSel_o(frameSel), .dirCode_o(dirCode), .mirrorX_o(mirrorX),
    .visible_o(visible), .isDead_o(isDead), .invulnerable_o(invulnerable),
    .deathDone_o(deathDone)
  );

  initial forever #5 clk = ~clk;

  // ---------------- behavioural model (elapsed-tick arithmetic) ----------------
  // mode: 0 idle, 1 walk, 2 dying, 3 dead
  int         m_mode;
  int         m_walk_t;   // ticks since walking started
  int         m_die_t;    // ticks since the hit was taken
  int         m_dead_t;   // ticks spent dead
  int         m_resp_t;   // ticks since respawn, saturating at INV
  bit         m_done, m_hitp, m_respp, m_pulse;
  logic [1:0] m_dir;
  logic       m_mir;

  function automatic void model_reset();
    m_mode = 0; m_walk_t = 0; m_die_t = 0; m_dead_t = 0; m_resp_t = INV;
    m_done = 0; m_hitp = 0; m_respp = 0; m_pulse = 0; m_dir = 2'd0; m_mir = 1'b0;
  endfunction

  function automatic void model_step();
    bit h, r, inv_now;
    m_pulse = 0;
    if (!(sof && en)) begin
      m_hitp  = m_hitp | hit;
      m_respp = m_respp | resp;
      return;
    end
    h = m_hitp | hit;
    r = m_respp | resp;
    m_hitp = 0; m_respp = 0;
    inv_now = (m_resp_t < INV);
    if (inv_now) m_resp_t++;
    if ((m_mode == 0 || m_mode == 1) && mv != 4'd0) begin
      if (mv[3])      begin m_dir = 2'd1; m_mir = 1'b0; end
      else if (mv[2]) begin m_dir = 2'd0; m_mir = 1'b0; end
      else if (mv[1]) begin m_dir = 2'd2; m_mir = 1'b1; end
      else            begin m_dir = 2'd2; m_mir = 1'b0; end
    end
    case (m_mode)
      0, 1: begin
        if (h && !inv_now) begin m_mode = 2; m_die_t = 0; end
        else if (mv == 4'd0) m_mode = 0;
        else if (m_mode == 0) begin m_mode = 1; m_walk_t = 0; end
        else m_walk_t++;
      end
      2: begin
        m_die_t++;
        if (m_die_t == FPS * DF) begin m_mode = 3; m_dead_t = 0; m_done = 0; end
      end
      default: begin
        if (r && m_done) begin
          m_mode = 0; m_dir = 2'd0; m_mir = 1'b0; m_resp_t = 0;
        end else if (!m_done) begin
          m_dead_t++;
          if (m_dead_t == DH) begin m_pulse = 1; m_done = 1; end
        end
      end
    endcase
  endfunction

  function automatic int e_frame();
    case (m_mode)
      0:       return 0;
      1:       return 1 + (m_walk_t / FPS) % WF;
      2:       return 8 + m_die_t / FPS;
      default: return 8 + DF - 1;
    endcase
  endfunction

  function automatic int e_inv();
    return (m_resp_t < INV) ? 1 : 0;
  endfunction

  function automatic int e_vis();
    if (m_resp_t < INV) return ((m_resp_t / BP) % 2 == 1) ? 1 : 0;
    return 1;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("frameSel",     8'(frameSel),     8'(e_frame()));
    check("dirCode",      8'(dirCode),      8'(m_dir));
    check("mirrorX",      8'(mirrorX),      8'(m_mir));
    check("visible",      8'(visible),      8'(e_vis()));
    check("isDead",       8'(isDead),       8'((m_mode >= 2) ? 1 : 0));
    check("invulnerable", 8'(invulnerable), 8'(e_inv()));
    check("deathDone",    8'(deathDone),    8'(m_pulse));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_frameSel"}, 8'(frameSel), 8'd0);
    check({tag, "_dirCode"},  8'(dirCode),  8'd0);
    check({tag, "_mirrorX"},  8'(mirrorX),  8'd0);
    check({tag, "_visible"},  8'(visible),  8'd1);
    check({tag, "_isDead"},   8'(isDead),   8'd0);
    check({tag, "_invuln"},   8'(invulnerable), 8'd0);
    check({tag, "_done"},     8'(deathDone), 8'd0);
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [3:0] rmv();
    return 4'($urandom_range(0, 15));
  endfunction

  // one clock: drive just after the falling edge, model at the rising edge,
  // compare at the next falling edge
  task automatic cyc(input logic s, input logic e, input logic [3:0] m,
                     input logic h, input logic r);
    #1;
    sof = s; en = e; mv = m; hit = h; resp = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  // n ticks with 0..2 idle cycles before each; hits may be injected between ticks
  task automatic run_ticks(input int n, input logic [3:0] m, input bit rnd,
                           input int unsigned hit_pct);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        cyc(1'b0, 1'b1, rnd ? rmv() : m, ($urandom_range(0, 99) < hit_pct), 1'b0);
      cyc(1'b1, 1'b1, rnd ? rmv() : m, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int dead_ticks;
    resetN = 1'b0; sof = 1'b0; en = 1'b1; mv = 4'd0; hit = 1'b0; resp = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    compare_model();
    resetN = 1'b1;

    // walk right: frame changes at ticks 1,7,13,19,25
    run_ticks(1, 4'b0001, 0, 0);
    check("walk_t1_frame", 8'(frameSel), 8'd1);
    check("walk_t1_dir",   8'(dirCode),  8'd2);
    check("walk_t1_mir",   8'(mirrorX),  8'd0);
    run_ticks(6, 4'b0001, 0, 0);
    check("walk_t7_frame", 8'(frameSel), 8'd2);
    run_ticks(12, 4'b0001, 0, 0);
    check("walk_t19_frame", 8'(frameSel), 8'd4);
    run_ticks(6, 4'b0001, 0, 0);
    check("walk_t25_frame", 8'(frameSel), 8'd1);
    run_ticks(3, 4'b0001, 0, 0);

    // paused for 10 frame pulses mid-walk
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, rmv(), 1'b0, 1'b0);
      cyc(1'b1, 1'b0, rmv(), 1'b0, 1'b0);
    end
    check("pause_frame", 8'(frameSel), 8'd1);
    check("pause_dir",   8'(dirCode),  8'd2);
    run_ticks(2, 4'b0001, 0, 0);
    check("resume_t30_frame", 8'(frameSel), 8'd1);
    run_ticks(1, 4'b0001, 0, 0);
    check("resume_t31_frame", 8'(frameSel), 8'd2);

    // up+left then release
    run_ticks(2, 4'b1010, 0, 0);
    check("upleft_dir", 8'(dirCode), 8'd1);
    check("upleft_mir", 8'(mirrorX), 8'd0);
    run_ticks(2, 4'b0000, 0, 0);
    check("release_frame", 8'(frameSel), 8'd0);
    check("release_dir",   8'(dirCode),  8'd1);

    // walk left, hit mid-frame
    run_ticks(5, 4'b0010, 0, 0);
    check("left_mir", 8'(mirrorX), 8'd1);
    cyc(1'b0, 1'b1, 4'b0010, 1'b1, 1'b0);
    run_ticks(1, 4'b0010, 0, 0);
    check("hit_isDead", 8'(isDead),   8'd1);
    check("hit_frame",  8'(frameSel), 8'd8);
    run_ticks(23, 4'd0, 1, 5);
    check("dying_last_frame", 8'(frameSel), 8'd11);
    run_ticks(1, 4'd0, 1, 0);
    check("dead_frame", 8'(frameSel), 8'd11);

    // respawn before deathDone is discarded
    cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    run_ticks(1, 4'd0, 1, 0);
    check("early_respawn_isDead", 8'(isDead), 8'd1);
    dead_ticks = 1;
    for (int k = 0; k < 200 && !m_pulse; k++) begin
      run_ticks(1, 4'd0, 1, 0);
      dead_ticks++;
    end
    check("dead_hold_ticks", 8'(dead_ticks), 8'(DH));
    check("deathDone_pulse", 8'(deathDone), 8'd1);
    run_ticks(3, 4'd0, 1, 0);
    check("deathDone_once", 8'(deathDone), 8'd0);

    // respawn on the tick cycle itself
    cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    check("respawn_isDead", 8'(isDead),       8'd0);
    check("respawn_inv",    8'(invulnerable), 8'd1);
    check("respawn_vis",    8'(visible),      8'd0);
    check("respawn_dir",    8'(dirCode),      8'd0);
    check("respawn_mir",    8'(mirrorX),      8'd0);
    run_ticks(8, 4'd0, 0, 0);
    check("blink_t8_vis", 8'(visible), 8'd1);
    run_ticks(110, 4'd0, 1, 10);   // hits here are discarded
    check("invuln_hit_isDead", 8'(isDead), 8'd0);
    run_ticks(1, 4'd0, 0, 0);
    check("invuln_t119", 8'(invulnerable), 8'd1);
    run_ticks(1, 4'd0, 0, 0);
    check("invuln_t120",  8'(invulnerable), 8'd0);
    check("invuln_t120_vis", 8'(visible),   8'd1);

    // hit and movement at the same tick
    cyc(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0);
    check("hit_move_isDead", 8'(isDead),   8'd1);
    check("hit_move_frame",  8'(frameSel), 8'd8);
    run_ticks(7, 4'd0, 1, 0);

    // asynchronous reset mid-dying
    #1;
    resetN = 1'b0; sof = 1'b0; hit = 1'b0; resp = 1'b0; mv = 4'd0;
    model_reset();
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    compare_model();
    resetN = 1'b1;

    // random soak
    for (int i = 0; i < 1200; i++)
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 3) == 0) ? 4'd0 : rmv(),
          ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
